wash_cycle: RTL

Wash-program sequencer for the washing-machine controller, on the receiving end of the billing stage's one-cycle `next` handshake. When billing signals that payment for the selected mode has cleared, this block latches the mode and runs the fixed wash → rinse → spin program with a 1 s countdown. It exposes the remaining time as two BCD digits for the 7-segment scanner and one-hot phase lamps for the LED bank, then returns a one-cycle `done` pulse.

---
 rtl/wash_cycle.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/wash_cycle.sv
// wash_cycle: wash-program sequencer started by the billing stage's one-cycle
// `next` pulse. It latches the selected mode and runs wash -> rinse -> spin
// with a 1 s countdown, then emits a one-cycle `done` pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start        one-cycle pulse, starts a program (accepted only in IDLE)
//   mode         2-bit program select, sampled with start
//   pause        level, freezes the countdown while high
//   busy         high while a program runs
//   done         one-cycle pulse when a program completes
//   t_hi, t_lo   remaining seconds as two BCD digits
//   phase_light  bit0 wash, bit1 rinse, bit2 spin, bit7 paused
module wash_cycle #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       pause,
    output logic       busy,
    output logic       done,
    output logic [3:0] t_hi,
    output logic [3:0] t_lo,
    output logic [7:0] phase_light
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {IDLE, WASH, RINSE, SPIN, DONE} state_t;

    state_t          state;
    state_t          nxt_state;
    logic [1:0]      mode_q;
    logic [4:0]      phase_cnt;
    logic [4:0]      nxt_cnt;
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    // Set on the first clock after reset release, so a start pulse that
    // coincides with reset deassertion is never taken.
    logic            armed;

    function automatic logic [4:0] wash_len(input logic [1:0] m);
        wash_len = 5'd0;
        case (m)
            2'b00: wash_len = 5'd0;
            2'b01: wash_len = 5'd10;
            2'b10: wash_len = 5'd15;
            2'b11: wash_len = 5'd20;
        endcase
    endfunction

    function automatic logic [4:0] rinse_len(input logic [1:0] m);
        rinse_len = 5'd0;
        case (m)
            2'b00: rinse_len = 5'd0;
            2'b01: rinse_len = 5'd6;
            2'b10: rinse_len = 5'd9;
            2'b11: rinse_len = 5'd12;
        endcase
    endfunction

    function automatic logic [4:0] spin_len(input logic [1:0] m);
        spin_len = 5'd0;
        case (m)
            2'b00: spin_len = 5'd6;
            2'b01: spin_len = 5'd4;
            2'b10: spin_len = 5'd6;
            2'b11: spin_len = 5'd8;
        endcase
    endfunction

    // Program total in seconds, already in BCD {tens, units}.
    function automatic logic [7:0] total_bcd(input logic [1:0] m);
        total_bcd = 8'h00;
        case (m)
            2'b00: total_bcd = 8'h06;
            2'b01: total_bcd = 8'h20;
            2'b10: total_bcd = 8'h30;
            2'b11: total_bcd = 8'h40;
        endcase
    endfunction

    function automatic logic [7:0] lamp(input state_t s, input logic p);
        lamp = {p, 7'b0000000};
        case (s)
            WASH:    lamp[0] = 1'b1;
            RINSE:   lamp[1] = 1'b1;
            SPIN:    lamp[2] = 1'b1;
            default: lamp = 8'h00;
        endcase
    endfunction

    // Tick detection and phase advance for the running states.
    always_comb begin
        tick      = 1'b0;
        nxt_state = state;
        nxt_cnt   = phase_cnt;
        if ((state == WASH || state == RINSE || state == SPIN) &&
            !pause && tick_cnt == TICK_LAST) begin
            tick    = 1'b1;
            nxt_cnt = phase_cnt - 5'd1;
            if (phase_cnt == 5'd1) begin
                case (state)
                    WASH: begin
                        nxt_state = RINSE;
                        nxt_cnt   = rinse_len(mode_q);
                    end
                    RINSE: begin
                        nxt_state = SPIN;
                        nxt_cnt   = spin_len(mode_q);
                    end
                    SPIN: begin
                        nxt_state = DONE;
                        nxt_cnt   = 5'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= 2'b00;
            phase_cnt   <= 5'd0;
            tick_cnt    <= '0;
            armed       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            t_hi        <= 4'd0;
            t_lo        <= 4'd0;
            phase_light <= 8'h00;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    phase_light <= 8'h00;
                    if (start && armed) begin
                        mode_q         <= mode;
                        {t_hi, t_lo}   <= total_bcd(mode);
                        tick_cnt       <= '0;
                        busy           <= 1'b1;
                        // Spin-only skips the zero-length wash and rinse.
                        if (mode == 2'b00) begin
                            state       <= SPIN;
                            phase_cnt   <= spin_len(mode);
                            phase_light <= lamp(SPIN, pause);
                        end else begin
                            state       <= WASH;
                            phase_cnt   <= wash_len(mode);
                            phase_light <= lamp(WASH, pause);
                        end
                    end
                end
                WASH, RINSE, SPIN: begin
                    if (!pause) begin
                        tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
                    end
                    if (tick) begin
                        if (t_lo == 4'd0) begin
                            t_lo <= 4'd9;
                            t_hi <= t_hi - 4'd1;
                        end else begin
                            t_lo <= t_lo - 4'd1;
                        end
                        state     <= nxt_state;
                        phase_cnt <= nxt_cnt;
                    end
                    busy        <= (nxt_state != DONE);
                    done        <= (nxt_state == DONE);
                    phase_light <= lamp(nxt_state, pause);
                end
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    phase_light <= 8'h00;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
